serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//  Bit-serial ripple adder/subtractor. It resolves one bit position per clock, LSB first, and keeps a registered carry between bits.
//  This is the sequential, area-minimal counterpart to the parallel combinational adder chain.
//  Subtraction computes a + ~b + 1; borrow-in is supported.
//  Sits between an operand producer and a result consumer, both using valid/ready handshakes.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block idle, can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: a+b+c_in; 1: a-b-c_in (c_in acts as borrow-in)
//  c_in       in   1      carry-in (add) / borrow-in (sub)
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  sum/difference, mod 2^WIDTH
//  carry_out  out  1      raw carry from MSB; in sub mode 1 = no borrow, 0 = borrow
//  overflow   out  1      signed overflow (only with SERIAL_ADD_SUB_OVF_EN)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=IDLE.
//   - result, carry_out, overflow, out_valid = 0; in_ready = 1.
//   - A reset mid-RUN or in DONE aborts the operation; the partial result is discarded.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready: latch a into a_sh, latch (sub ? ~b : b) into b_sh.
//   - Set carry = sub ? ~c_in : c_in; clear bit_cnt and result; go to RUN.
//  RUN (in_ready=0, out_valid=0):
//   - Each cycle: s = a_sh[0]^b_sh[0]^carry; carry <= maj(a_sh[0], b_sh[0], carry).
//   - Shift a_sh and b_sh right; shift s into result from the MSB end.
//   - bit_cnt++. After bit WIDTH-1 is processed, go to DONE.
//  DONE:
//   - out_valid=1; result and carry_out are stable.
//   - On out_ready, go to IDLE.
//  Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
//  Throughput: one operation per WIDTH+2 cycles at best; no overlap between operations.
//  in_valid while not in IDLE is ignored; latched operands are never disturbed.
//  out_valid, result and carry_out must not change while out_valid=1 && out_ready=0.
//  Counter: bit_cnt is $clog2(WIDTH) bits wide and must not wrap before DONE.
//  The result register is not cleared on DONE->IDLE; it keeps its value until the next accept.
// CONFIGURATION
//  SERIAL_ADD_SUB_OVF_EN defined:
//   - The overflow port exists.
//   - Record the carry into the MSB (the carry before the last RUN step).
//   - At the last step, overflow <= cin_msb ^ cout_msb; it is valid with out_valid.
//  SERIAL_ADD_SUB_OVF_EN undefined: the port and its logic are absent.
// STRUCTURE
//  Package serial_add_sub_pkg:
//   - typedef enum {IDLE, RUN, DONE} state_t.
//   - Function cnt_w(WIDTH) for the bit_cnt width.
//  One leaf sub-module, fa_bit_cell: combinational 1-bit full adder (a, b, c -> s, co), instantiated once.
// TESTING (WIDTH=4)
//  1. add 5+3, c_in=0 -> result=8, carry_out=0, overflow=1; out_valid 4 cycles after accept.
//  2. add 15+1, c_in=0 -> result=0, carry_out=1, overflow=0.
//  3. sub 7-2 -> result=5, carry_out=1. Then sub 2-7 -> result=11, carry_out=0, overflow=0.
//  4. out_ready=0 for 3 cycles in DONE -> out_valid=1, result held, in_ready=0. Then out_ready=1 -> IDLE next cycle.
//  5. rst_n=0 after 2 RUN cycles -> out_valid=0, result=0, in_ready=1 on the next cycle.
//  6. New in_valid with a=9 during RUN -> ignored; the first operation's result is unchanged.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// The FSM state type and the bit-counter width function live here.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_sub_fa_bit_cell.sv
// Combinational 1-bit full adder: one ripple stage reused every cycle
// by the serial adder.
module fa_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial ripple adder/subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADD_SUB_OVF_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, result_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             carry_q;
  logic             s_bit, co_bit;
  logic             accept, running, last_step;

  fa_bit_cell u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (s_bit),
    .co_o (co_bit)
  );

  assign accept    = (state_q == IDLE) && in_valid;
  assign running   = (state_q == RUN);
  assign last_step = running && (bit_cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Carry, counter and result are visible state and are reset;
  // the operand shifters only matter during RUN and are not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q  <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
    end else if (accept) begin
      result_q  <= '0;
      carry_q   <= sub ? ~c_in : c_in;
      bit_cnt_q <= '0;
    end else if (running) begin
      result_q  <= {s_bit, result_q[WIDTH-1:1]};
      carry_q   <= co_bit;
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh_q <= a;
      b_sh_q <= sub ? ~b : b;
    end else if (running) begin
      a_sh_q <= a_sh_q >> 1;
      b_sh_q <= b_sh_q >> 1;
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ovf_q;

  // carry_q at the last step is the carry into the MSB
  always_ff @(posedge clk) begin
    if (!rst_n)         ovf_q <= 1'b0;
    else if (accept)    ovf_q <= 1'b0;
    else if (last_step) ovf_q <= carry_q ^ co_bit;
  end

  assign overflow = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=4) with an expected-result queue.
module tb_serial_add_sub;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry_out;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef SERIAL_ADD_SUB_OVF_EN
    .overflow  (overflow),
`endif
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic ci);
    exp_t e;
    int   sa, sb_v, sr;
    logic [W:0] sum;
    sa   = (x >= (1 << (W-1))) ? int'(x) - (1 << W) : int'(x);
    sb_v = (y >= (1 << (W-1))) ? int'(y) - (1 << W) : int'(y);
    if (!s) begin
      sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      sr  = sa + sb_v + int'(ci);
    end else begin
      sum = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, ~ci};
      sr  = sa - sb_v - int'(ci);
    end
    e.res = sum[W-1:0];
    e.co  = sum[W];
    e.ov  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return e;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after accept.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input logic ci);
    a = x; b = y; sub = s; c_in = ci; in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(x, y, s, ci));
  endtask

  // Waits (bounded) for out_valid, checks latency and data against the queue.
  task automatic collect(input string tag, input int elapsed);
    int   cyc;
    exp_t e;
    cyc = elapsed;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(W));
    if (sb.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_result"}, 32'(result), 32'(e.res));
    chk({tag, "_carry"}, 32'(carry_out), 32'(e.co));
`ifdef SERIAL_ADD_SUB_OVF_EN
    chk({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
`endif
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_back_to_idle"}, 32'(in_ready), 32'd1);
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] held;
    exp_t         dump;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed add / subtract cases
    issue(4'd5, 4'd3, 1'b0, 1'b0);   collect("add_5_3", 0);
    issue(4'd15, 4'd1, 1'b0, 1'b0);  collect("add_15_1", 0);
    issue(4'd7, 4'd2, 1'b1, 1'b0);   collect("sub_7_2", 0);
    issue(4'd2, 4'd7, 1'b1, 1'b0);   collect("sub_2_7", 0);
    issue(4'd6, 4'd9, 1'b0, 1'b1);   collect("add_cin", 0);
    issue(4'd8, 4'd3, 1'b1, 1'b1);   collect("sub_borrow", 0);

    // Back-pressure in DONE
    out_ready = 1'b0;
    issue(4'd10, 4'd4, 1'b0, 1'b0);
    collect("hold", 0);
    held = result;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'(held));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", 32'(in_ready), 32'd1);
    chk("release_valid", 32'(out_valid), 32'd0);

    // Reset after two RUN cycles aborts the operation
    issue(4'd11, 4'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("run_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dump = sb.pop_front();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);

    // in_valid during RUN is ignored
    issue(4'd3, 4'd4, 1'b0, 1'b0);
    a = 4'd9; b = 4'd9; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect("ignore_busy", 2);

    // A handful of random operations
    for (int i = 0; i < 8; i++) begin
      issue(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      collect("rand", 0);
    end

    chk("queue_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
